alu_rs: RTL and testbench
=========================

# alu_rs

ALU reservation station: the issue-side producer that drives the ALU's `rob_id_in/valid/op/v1/v2` inputs. It buffers decoded integer and branch-compare micro-ops and snoops the ALU and LSB result broadcasts for missing operands. Each cycle it dispatches at most one operand-complete entry to the ALU. It sits between the decoder/issue stage and the ALU, and is cleared by the ROB on misprediction.

## Interface
- `RS_SIZE`, default `` `RS_SIZE `` (8): number of entries.
- `RS_SIZE_WIDTH`, default `` `RS_SIZE_WIDTH `` (3): entry index width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rdy`  in  1: global clock enable; when low, all state and outputs hold.
- `rob_clear`  in  1: flush from ROB (mispredict).
- `issue_valid`  in  1: new micro-op this cycle.
- `issue_op`  in  5: op[4] branch compare, op[3] sub/sra, op[2:0] funct3; passed through unchanged.
- `issue_rob_id`  in  `ROB_SIZE_WIDTH`: destination ROB tag.
- `issue_vj`, `issue_vk`  in  32: operand values, valid when the matching `_has_dep` is 0.
- `issue_qj`, `issue_qk`  in  `ROB_SIZE_WIDTH`: producer tags.
- `issue_qj_has_dep`, `issue_qk_has_dep`  in  1: operand still pending.
- `alu_cdb_ready`  in  1, `alu_cdb_rob_id`  in  `ROB_SIZE_WIDTH`, `alu_cdb_result`  in  32: ALU broadcast.
- `lsb_cdb_ready`  in  1, `lsb_cdb_rob_id`  in  `ROB_SIZE_WIDTH`, `lsb_cdb_result`  in  32: LSB broadcast.
- `full`  out  1: all entries busy; combinational from current state.
- `alu_valid`  out  1, `alu_op`  out  5, `alu_v1`, `alu_v2`  out  32, `alu_rob_id`  out  `ROB_SIZE_WIDTH`: registered dispatch to ALU.

## Operation
- Each entry holds: busy, op, rob_id, vj, vk, qj, qk, qj_dep, qk_dep.
- **Issue.** When `issue_valid` and `!full`, write the lowest-index free entry and set busy=1. Issue while `full` is a protocol violation; the op is dropped and no state changes.
- **Issue bypass.** If a pending issue operand tag equals a same-cycle broadcast tag with its ready bit high, capture the broadcast value and clear the dep bit at write time.
- **Wakeup.** For every busy entry with qj_dep (or qk_dep) set and a broadcast tag match, latch the broadcast value and clear the dep bit.
  - If both buses match the same tag, ALU wins. ROB tags are unique, so this is defensive only.
  - qj and qk are woken independently; both may wake in the same cycle.
- **Dispatch.** Candidates are entries that are busy with both dep bits clear in the state at cycle start. Pick the lowest index.
  - Register its op/vj/vk/rob_id onto `alu_*`, assert `alu_valid`, and clear busy.
  - With no candidate, drive `alu_valid`=0; the other `alu_*` outputs hold their last value.
- **Slot reuse.** Issue and dispatch are allowed in the same cycle. The slot freed by dispatch is not reusable until the next cycle, because `full` and free-slot selection both come from cycle-start state.
- **Flush.** `rob_clear` clears all busy bits and sets `alu_valid`=0 at the next edge. It overrides issue, wakeup and dispatch in that cycle.
- **Priority.** `rst` > `!rdy` hold > `rob_clear` > normal.
- **Reset.** All busy and dep bits are 0. `alu_valid`, `alu_op`, `alu_v1`, `alu_v2` and `alu_rob_id` are 0. `full` is 0.

## Timing
- An issue with both operands ready at edge N is dispatched at edge N+1: `alu_valid` is high during cycle N+1, and the ALU result appears after edge N+2.
- A broadcast matching an entry at edge N makes that entry dispatchable at edge N+1.
- A bypassed issue (broadcast in the issue cycle) behaves as a ready issue: written at N, dispatched at N+1.
- Throughput is one dispatch per cycle.
- `full` deasserts in the cycle after the edge that frees an entry.
- `rdy` low for k cycles stretches every latency by k. No broadcast is lost, because the broadcast sources are stalled by the same `rdy`.

## Structure
- Shared `config.v` macros:
  - `RS_SIZE`, `RS_SIZE_WIDTH`, `ROB_SIZE_WIDTH`.
  - The 5-bit ALU op encoding constants: branch bit 4, alt bit 3, funct3 bits 2:0.
- One sub-module, `rs_pick`: a parameterised lowest-index priority encoder (`RS_SIZE`-bit request vector in; found flag and index out). It is instantiated twice, once for free-slot selection and once for ready-entry selection.

## Test plan
- **Reset.** Hold `rst` for 2 cycles → `full`=0, `alu_valid`=0, all `alu_*`=0.
- **Ready issue.** Issue op=5'b00000, vj=5, vk=7, rob=3, no deps at edge 0 → edge 1: `alu_valid`=1, `alu_op`=0, `alu_v1`=5, `alu_v2`=7, `alu_rob_id`=3; edge 2: `alu_valid`=0.
- **Wakeup.** Issue with qj=2 (dep) and vk=1 at edge 0; LSB broadcasts rob 2 = 0x10 at edge 2 → dispatch at edge 3 with v1=0x10, v2=1; no dispatch at edges 1–2.
- **Bypass and ordering.**
  - Issue qj=4 (dep) while ALU broadcasts rob 4 = 9 in the same cycle → dispatch next edge with v1=9.
  - Two ready entries in slots 0 and 1 → slot 0 dispatches first, slot 1 on the following edge.
- **Full.** Issue 8 ops all dependent on rob 7 → `full`=1; a 9th issue is dropped. ALU broadcasts rob 7 → 8 consecutive dispatches from slots 0 through 7; `full` falls after the first dispatch edge.
- **Flush and stall.**
  - Hold `rdy`=0 for 3 cycles with a ready entry → no state change; dispatch occurs on the first `rdy`=1 edge.
  - Assert `rob_clear` with 4 busy entries plus a simultaneous issue → next edge: `alu_valid`=0, `full`=0, no later dispatch.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// ALU reservation station shared types and sizing.
// Entry layout, op encoding and the broadcast snoop helper.
package alu_rs_pkg;

    localparam int RS_SIZE_DEF       = 8;
    localparam int RS_SIZE_WIDTH_DEF = 3;
    localparam int ROB_SIZE_WIDTH    = 4;

    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    // ALU op: bit 4 branch compare, bit 3 sub/sra, bits 2:0 funct3
    typedef struct packed {
        logic       branch;
        logic       alt;
        logic [2:0] funct3;
    } alu_op_t;

    typedef struct packed {
        logic        dep;
        logic [31:0] val;
    } opnd_t;

    typedef struct packed {
        logic        busy;
        alu_op_t     op;
        rob_id_t     rob_id;
        logic [31:0] vj;
        logic [31:0] vk;
        rob_id_t     qj;
        rob_id_t     qk;
        logic        qj_dep;
        logic        qk_dep;
    } rs_entry_t;

    // Resolve a pending operand against both result buses; ALU wins a tie.
    function automatic opnd_t snoop(
        input logic        dep,
        input rob_id_t     q,
        input logic [31:0] v,
        input logic        a_rdy,
        input rob_id_t     a_id,
        input logic [31:0] a_res,
        input logic        l_rdy,
        input rob_id_t     l_id,
        input logic [31:0] l_res
    );
        opnd_t r;
        r.dep = dep;
        r.val = v;
        if (dep && a_rdy && a_id == q) begin
            r.dep = 1'b0;
            r.val = a_res;
        end else if (dep && l_rdy && l_id == q) begin
            r.dep = 1'b0;
            r.val = l_res;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder.
// Used for both free-slot and ready-entry selection.
module rs_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // Scan high to low so the lowest set request wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers micro-ops, snoops the ALU/LSB
// result buses and dispatches one operand-complete entry per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE       = RS_SIZE_DEF,
    parameter int RS_SIZE_WIDTH = RS_SIZE_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rob_clear,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_op,
    input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    input  logic [31:0]               issue_vj,
    input  logic [31:0]               issue_vk,
    input  logic [ROB_SIZE_WIDTH-1:0] issue_qj,
    input  logic [ROB_SIZE_WIDTH-1:0] issue_qk,
    input  logic                      issue_qj_has_dep,
    input  logic                      issue_qk_has_dep,
    input  logic                      alu_cdb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]               alu_cdb_result,
    input  logic                      lsb_cdb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]               lsb_cdb_result,
    output logic                      full,
    output logic                      alu_valid,
    output logic [4:0]                alu_op,
    output logic [31:0]               alu_v1,
    output logic [31:0]               alu_v2,
    output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id
);

    rs_entry_t r_ent [RS_SIZE];

    logic        r_alu_valid;
    alu_op_t     r_alu_op;
    logic [31:0] r_alu_v1;
    logic [31:0] r_alu_v2;
    rob_id_t     r_alu_rob_id;

    logic [RS_SIZE-1:0]       w_busy;
    logic [RS_SIZE-1:0]       w_ready;
    logic                     w_free_found;
    logic [RS_SIZE_WIDTH-1:0] w_free_idx;
    logic                     w_rdy_found;
    logic [RS_SIZE_WIDTH-1:0] w_rdy_idx;
    opnd_t                    w_iss_j;
    opnd_t                    w_iss_k;

    // Busy and dispatch-candidate vectors from cycle-start state
    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_busy[i]  = r_ent[i].busy;
            w_ready[i] = r_ent[i].busy & ~r_ent[i].qj_dep
                       & ~r_ent[i].qk_dep;
        end
    end

    // Issue operands with same-cycle broadcast bypass
    always_comb begin
        w_iss_j = snoop(issue_qj_has_dep, issue_qj, issue_vj,
                        alu_cdb_ready, alu_cdb_rob_id, alu_cdb_result,
                        lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_result);
        w_iss_k = snoop(issue_qk_has_dep, issue_qk, issue_vk,
                        alu_cdb_ready, alu_cdb_rob_id, alu_cdb_result,
                        lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_result);
    end

    rs_pick #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_free_pick (
        .i_req   (~w_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_pick #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_rdy_pick (
        .i_req   (w_ready),
        .o_found (w_rdy_found),
        .o_idx   (w_rdy_idx)
    );

    assign full       = &w_busy;
    assign alu_valid  = r_alu_valid;
    assign alu_op     = r_alu_op;
    assign alu_v1     = r_alu_v1;
    assign alu_v2     = r_alu_v2;
    assign alu_rob_id = r_alu_rob_id;

    // Entry state: flush, wakeup, dispatch and issue
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_ent[i] <= '0;
            end
            r_alu_valid  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_v1     <= '0;
            r_alu_v2     <= '0;
            r_alu_rob_id <= '0;
        end else if (rdy) begin
            if (rob_clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_ent[i].busy <= 1'b0;
                end
                r_alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_ent[i].busy) begin
                        opnd_t t_j;
                        opnd_t t_k;
                        t_j = snoop(r_ent[i].qj_dep, r_ent[i].qj,
                                    r_ent[i].vj, alu_cdb_ready,
                                    alu_cdb_rob_id, alu_cdb_result,
                                    lsb_cdb_ready, lsb_cdb_rob_id,
                                    lsb_cdb_result);
                        t_k = snoop(r_ent[i].qk_dep, r_ent[i].qk,
                                    r_ent[i].vk, alu_cdb_ready,
                                    alu_cdb_rob_id, alu_cdb_result,
                                    lsb_cdb_ready, lsb_cdb_rob_id,
                                    lsb_cdb_result);
                        r_ent[i].qj_dep <= t_j.dep;
                        r_ent[i].vj     <= t_j.val;
                        r_ent[i].qk_dep <= t_k.dep;
                        r_ent[i].vk     <= t_k.val;
                    end
                end

                r_alu_valid <= w_rdy_found;
                if (w_rdy_found) begin
                    r_alu_op              <= r_ent[w_rdy_idx].op;
                    r_alu_v1              <= r_ent[w_rdy_idx].vj;
                    r_alu_v2              <= r_ent[w_rdy_idx].vk;
                    r_alu_rob_id          <= r_ent[w_rdy_idx].rob_id;
                    r_ent[w_rdy_idx].busy <= 1'b0;
                end

                if (issue_valid && !full && w_free_found) begin
                    r_ent[w_free_idx].busy   <= 1'b1;
                    r_ent[w_free_idx].op     <= alu_op_t'(issue_op);
                    r_ent[w_free_idx].rob_id <= issue_rob_id;
                    r_ent[w_free_idx].qj     <= issue_qj;
                    r_ent[w_free_idx].qk     <= issue_qk;
                    r_ent[w_free_idx].qj_dep <= w_iss_j.dep;
                    r_ent[w_free_idx].vj     <= w_iss_j.val;
                    r_ent[w_free_idx].qk_dep <= w_iss_k.dep;
                    r_ent[w_free_idx].vk     <= w_iss_k.val;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed issue sequences with a
// dispatch scoreboard checked by an independent monitor.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_clear;
    logic        issue_valid;
    logic [4:0]  issue_op;
    logic [3:0]  issue_rob_id;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic        issue_qj_has_dep;
    logic        issue_qk_has_dep;
    logic        alu_cdb_ready;
    logic [3:0]  alu_cdb_rob_id;
    logic [31:0] alu_cdb_result;
    logic        lsb_cdb_ready;
    logic [3:0]  lsb_cdb_rob_id;
    logic [31:0] lsb_cdb_result;
    logic        full;
    logic        alu_valid;
    logic [4:0]  alu_op;
    logic [31:0] alu_v1;
    logic [31:0] alu_v2;
    logic [3:0]  alu_rob_id;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_rs dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .rob_clear        (rob_clear),
        .issue_valid      (issue_valid),
        .issue_op         (issue_op),
        .issue_rob_id     (issue_rob_id),
        .issue_vj         (issue_vj),
        .issue_vk         (issue_vk),
        .issue_qj         (issue_qj),
        .issue_qk         (issue_qk),
        .issue_qj_has_dep (issue_qj_has_dep),
        .issue_qk_has_dep (issue_qk_has_dep),
        .alu_cdb_ready    (alu_cdb_ready),
        .alu_cdb_rob_id   (alu_cdb_rob_id),
        .alu_cdb_result   (alu_cdb_result),
        .lsb_cdb_ready    (lsb_cdb_ready),
        .lsb_cdb_rob_id   (lsb_cdb_rob_id),
        .lsb_cdb_result   (lsb_cdb_result),
        .full             (full),
        .alu_valid        (alu_valid),
        .alu_op           (alu_op),
        .alu_v1           (alu_v1),
        .alu_v2           (alu_v2),
        .alu_rob_id       (alu_rob_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_issue();
        issue_valid      = 1'b0;
        issue_op         = '0;
        issue_rob_id     = '0;
        issue_vj         = '0;
        issue_vk         = '0;
        issue_qj         = '0;
        issue_qk         = '0;
        issue_qj_has_dep = 1'b0;
        issue_qk_has_dep = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] rob,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic jd, input logic [3:0] qj);
        issue_valid      = 1'b1;
        issue_op         = op;
        issue_rob_id     = rob;
        issue_vj         = vj;
        issue_vk         = vk;
        issue_qj         = qj;
        issue_qk         = '0;
        issue_qj_has_dep = jd;
        issue_qk_has_dep = 1'b0;
    endtask

    task automatic push(input logic [4:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [3:0] rob);
        exp_t e;
        e.op  = op;
        e.v1  = v1;
        e.v2  = v2;
        e.rob = rob;
        exp_q.push_back(e);
    endtask

    // Monitor: every dispatch must match the oldest expectation
    always @(negedge clk) begin
        if (alu_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dispatch: got rob %0h expected none",
                         alu_rob_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("disp_op",  32'(alu_op),     32'(e.op));
                chk("disp_v1",  alu_v1,          e.v1);
                chk("disp_v2",  alu_v2,          e.v2);
                chk("disp_rob", 32'(alu_rob_id), 32'(e.rob));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        rob_clear      = 1'b0;
        alu_cdb_ready  = 1'b0;
        alu_cdb_rob_id = '0;
        alu_cdb_result = '0;
        lsb_cdb_ready  = 1'b0;
        lsb_cdb_rob_id = '0;
        lsb_cdb_result = '0;
        idle_issue();

        tick();
        tick();
        chk("rst_full",  32'(full),       0);
        chk("rst_valid", 32'(alu_valid),  0);
        chk("rst_op",    32'(alu_op),     0);
        chk("rst_v1",    alu_v1,          0);
        chk("rst_v2",    alu_v2,          0);
        chk("rst_rob",   32'(alu_rob_id), 0);
        rst = 1'b0;
        tick();

        // Ready issue
        issue(5'b00000, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0);
        push(5'b00000, 32'd5, 32'd7, 4'd3);
        tick();
        idle_issue();
        chk("ready_e0_valid", 32'(alu_valid), 0);
        tick();
        chk("ready_e1_valid", 32'(alu_valid), 1);
        tick();
        chk("ready_e2_valid", 32'(alu_valid), 0);

        // Wakeup from LSB
        issue(5'b01000, 4'd5, 32'd0, 32'd1, 1'b1, 4'd2);
        push(5'b01000, 32'h10, 32'd1, 4'd5);
        tick();
        idle_issue();
        tick();
        chk("wake_e1_valid", 32'(alu_valid), 0);
        lsb_cdb_ready  = 1'b1;
        lsb_cdb_rob_id = 4'd2;
        lsb_cdb_result = 32'h10;
        tick();
        lsb_cdb_ready = 1'b0;
        chk("wake_e2_valid", 32'(alu_valid), 0);
        tick();
        chk("wake_e3_valid", 32'(alu_valid), 1);
        tick();

        // Issue bypass from ALU broadcast
        issue(5'b00010, 4'd6, 32'd0, 32'd3, 1'b1, 4'd4);
        alu_cdb_ready  = 1'b1;
        alu_cdb_rob_id = 4'd4;
        alu_cdb_result = 32'd9;
        push(5'b00010, 32'd9, 32'd3, 4'd6);
        tick();
        idle_issue();
        alu_cdb_ready = 1'b0;
        tick();
        chk("byp_valid", 32'(alu_valid), 1);
        tick();

        // Two simultaneously ready entries: slot 0 first
        issue(5'b00100, 4'd1, 32'd0, 32'hA, 1'b1, 4'd8);
        push(5'b00100, 32'h55, 32'hA, 4'd1);
        tick();
        issue(5'b00110, 4'd2, 32'd0, 32'hB, 1'b1, 4'd8);
        push(5'b00110, 32'h55, 32'hB, 4'd2);
        tick();
        idle_issue();
        alu_cdb_ready  = 1'b1;
        alu_cdb_rob_id = 4'd8;
        alu_cdb_result = 32'h55;
        tick();
        alu_cdb_ready = 1'b0;
        tick();
        chk("order_first", 32'(alu_rob_id), 1);
        tick();
        chk("order_second", 32'(alu_rob_id), 2);
        tick();

        // Fill all eight slots, drop a ninth
        for (int i = 0; i < 8; i++) begin
            issue(5'(i), 4'(i), 32'd0, 32'(100 + i), 1'b1, 4'd7);
            push(5'(i), 32'h70, 32'(100 + i), 4'(i));
            tick();
        end
        idle_issue();
        chk("full_set", 32'(full), 1);
        issue(5'b00001, 4'd15, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0);
        tick();
        idle_issue();
        chk("full_drop_full",  32'(full),      1);
        chk("full_drop_valid", 32'(alu_valid), 0);
        alu_cdb_ready  = 1'b1;
        alu_cdb_rob_id = 4'd7;
        alu_cdb_result = 32'h70;
        tick();
        alu_cdb_ready = 1'b0;
        chk("full_wake_full", 32'(full), 1);
        tick();
        chk("full_first_valid", 32'(alu_valid), 1);
        chk("full_falls",       32'(full),      0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("full_drain_valid", 32'(alu_valid), 1);
        end
        tick();
        chk("full_done_valid", 32'(alu_valid), 0);

        // rdy stall stretches dispatch
        issue(5'b10001, 4'd9, 32'h11, 32'h22, 1'b0, 4'd0);
        push(5'b10001, 32'h11, 32'h22, 4'd9);
        tick();
        idle_issue();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(alu_valid), 0);
        end
        rdy = 1'b1;
        tick();
        chk("stall_release", 32'(alu_valid), 1);
        tick();

        // Flush with busy entries and a simultaneous issue
        for (int i = 0; i < 3; i++) begin
            issue(5'b00000, 4'(10 + i), 32'd0, 32'd1, 1'b1, 4'd12);
            tick();
        end
        issue(5'b00000, 4'd13, 32'd1, 32'd2, 1'b0, 4'd0);
        tick();
        rob_clear = 1'b1;
        issue(5'b00000, 4'd14, 32'd3, 32'd4, 1'b0, 4'd0);
        tick();
        rob_clear = 1'b0;
        idle_issue();
        chk("flush_valid", 32'(alu_valid), 0);
        chk("flush_full",  32'(full),      0);
        alu_cdb_ready  = 1'b1;
        alu_cdb_rob_id = 4'd12;
        alu_cdb_result = 32'h99;
        tick();
        alu_cdb_ready = 1'b0;
        tick();
        tick();
        chk("flush_after_valid", 32'(alu_valid), 0);
        tick();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
